// File: rtl/hpss_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : hpss_seq_if
//  Description : Control/status bundle between the HPSS frame sequencer and
//                the stage pipeline / FIFO level monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hpss_seq_if #(
    parameter int NSTAGE  = 6,
    parameter int LEVEL_W = 12
);
    logic               enable;
    logic [LEVEL_W-1:0] in_level;
    logic [LEVEL_W-1:0] out_level;
    logic [NSTAGE-1:0]  stage_done;
    logic [NSTAGE-1:0]  stage_start;
    logic [NSTAGE-1:0]  stage_busy;
    logic               busy;
    logic               frame_done;
    logic [15:0]        frame_cnt;
    logic               abort;
    logic               tmo_err;
    logic [2:0]         err_stage;
    logic               clr_err;

    modport master (
        input  enable, in_level, out_level, stage_done, clr_err,
        output stage_start, stage_busy, busy, frame_done, frame_cnt,
               abort, tmo_err, err_stage
    );

    modport slave (
        output enable, in_level, out_level, stage_done, clr_err,
        input  stage_start, stage_busy, busy, frame_done, frame_cnt,
               abort, tmo_err, err_stage
    );
endinterface
`default_nettype wire

// File: rtl/hpss_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hpss_frame_sequencer
//  Description : Steps each frame through NSTAGE pipeline stages with start
//                pulses / done handshakes; optional per-stage hang watchdog
//                enabled by macro HPSS_SEQ_WATCHDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module hpss_frame_sequencer #(
    parameter int NSTAGE    = 6,
    parameter int LEVEL_W   = 12,
    parameter int FRAME_LEN = 512,
    parameter int OUT_DEPTH = 2048,
    parameter int OUT_ROOM  = 512,
    parameter int TMO_W     = 16,
    parameter int TMO_CYC   = 40000
) (
    input  logic       clk,
    input  logic       rst,
    hpss_seq_if.master seq
);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [LEVEL_W-1:0] c_IN_MIN   = LEVEL_W'(FRAME_LEN - 1);
    localparam logic [LEVEL_W-1:0] c_OUT_MAX  = LEVEL_W'(OUT_DEPTH - OUT_ROOM);
    localparam logic [2:0]         c_LAST_IDX = 3'(NSTAGE - 1);

    logic [1:0]        state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [NSTAGE-1:0] stage_start_q, stage_start_d;
    logic [NSTAGE-1:0] stage_busy_q, stage_busy_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic              w_launch;
    logic              w_done_acc;
    logic              w_last;
    logic              w_tmo;
    logic [2:0]        w_idx_inc;
    logic [NSTAGE-1:0] w_next_onehot;

    assign w_launch = seq.enable && (seq.in_level >= c_IN_MIN) &&
                      (seq.out_level <= c_OUT_MAX);
    // A done overlapping the start pulse belongs to the previous use of the stage.
    assign w_done_acc    = (state_q == c_RUN) && (stage_start_q == '0) &&
                           seq.stage_done[idx_q];
    assign w_last        = (idx_q == c_LAST_IDX);
    assign w_idx_inc     = idx_q + 3'd1;
    assign w_next_onehot = NSTAGE'(1) << w_idx_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= c_IDLE;
            idx_q         <= 3'd0;
            stage_start_q <= '0;
            stage_busy_q  <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            stage_start_q <= stage_start_d;
            stage_busy_q  <= stage_busy_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: if (seq.enable) state_d = c_WAIT;
            c_WAIT: begin
                if (!seq.enable)   state_d = c_IDLE;
                else if (w_launch) state_d = c_RUN;
            end
            c_RUN: begin
                if (w_done_acc && w_last) state_d = c_DONE;
                else if (w_tmo)           state_d = c_WAIT;
            end
            c_DONE:  state_d = seq.enable ? c_WAIT : c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        idx_d         = idx_q;
        stage_start_d = '0;
        stage_busy_d  = stage_busy_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        case (state_q)
            c_IDLE: begin
                stage_busy_d = '0;
                busy_d       = 1'b0;
            end
            c_WAIT: begin
                if (w_launch) begin
                    idx_d         = 3'd0;
                    stage_start_d = NSTAGE'(1);
                    stage_busy_d  = NSTAGE'(1);
                    busy_d        = 1'b1;
                end
            end
            c_RUN: begin
                if (w_done_acc) begin
                    if (w_last) begin
                        stage_busy_d = '0;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                    end else begin
                        idx_d         = w_idx_inc;
                        stage_start_d = w_next_onehot;
                        stage_busy_d  = w_next_onehot;
                    end
                end else if (w_tmo) begin
                    stage_busy_d = '0;
                    busy_d       = 1'b0;
                end
            end
            c_DONE: begin
                idx_d  = 3'd0;
                busy_d = 1'b0;
            end
            default: begin
                stage_busy_d = '0;
                busy_d       = 1'b0;
            end
        endcase
    end

`ifdef HPSS_SEQ_WATCHDOG_EN
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic [TMO_W-1:0] wdg_q, wdg_d;
    logic             abort_q, abort_d;
    logic             tmo_err_q, tmo_err_d;
    logic [2:0]       err_stage_q, err_stage_d;

    assign w_tmo = (state_q == c_RUN) && (wdg_q == c_TMO_LAST) && !w_done_acc;

    always_comb begin
        wdg_d       = wdg_q;
        abort_d     = w_tmo;
        tmo_err_d   = tmo_err_q;
        err_stage_d = err_stage_q;
        if (stage_start_d != '0)  wdg_d = '0;
        else if (state_q == c_RUN) wdg_d = wdg_q + 1'b1;
        if (seq.clr_err) begin
            tmo_err_d   = 1'b0;
            err_stage_d = 3'd0;
        end
        // A fresh timeout outranks a simultaneous clear.
        if (w_tmo) begin
            tmo_err_d   = 1'b1;
            err_stage_d = idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdg_q       <= '0;
            abort_q     <= 1'b0;
            tmo_err_q   <= 1'b0;
            err_stage_q <= 3'd0;
        end else begin
            wdg_q       <= wdg_d;
            abort_q     <= abort_d;
            tmo_err_q   <= tmo_err_d;
            err_stage_q <= err_stage_d;
        end
    end

    assign seq.abort     = abort_q;
    assign seq.tmo_err   = tmo_err_q;
    assign seq.err_stage = err_stage_q;
`else
    logic w_unused_cfg;

    assign w_tmo         = 1'b0;
    assign w_unused_cfg  = seq.clr_err ^ (TMO_W > 0) ^ (TMO_CYC > 0);
    assign seq.abort     = 1'b0;
    assign seq.tmo_err   = 1'b0;
    assign seq.err_stage = 3'd0;
`endif

    assign seq.stage_start = stage_start_q;
    assign seq.stage_busy  = stage_busy_q;
    assign seq.busy        = busy_q;
    assign seq.frame_done  = frame_done_q;
    assign seq.frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hpss_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hpss_frame_sequencer
//  Description : Directed self-checking bench for hpss_frame_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hpss_frame_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asrt = 0;
    int   n_fail = 0;
    int   seen;

    hpss_seq_if #(.NSTAGE(6), .LEVEL_W(12)) sif ();

    hpss_frame_sequencer #(.TMO_CYC(50)) dut (
        .clk (clk),
        .rst (rst),
        .seq (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".stage_start"}, 32'(sif.stage_start), 0);
        chk({tag, ".stage_busy"},  32'(sif.stage_busy), 0);
        chk({tag, ".busy"},        32'(sif.busy), 0);
        chk({tag, ".frame_done"},  32'(sif.frame_done), 0);
        chk({tag, ".frame_cnt"},   32'(sif.frame_cnt), 0);
        chk({tag, ".abort"},       32'(sif.abort), 0);
        chk({tag, ".tmo_err"},     32'(sif.tmo_err), 0);
        chk({tag, ".err_stage"},   32'(sif.err_stage), 0);
    endtask

    // Entered at the negedge where stage k's start pulse is visible; returns
    // at the negedge one cycle after done[k] was presented.
    task automatic step_stage(input int k, input int dly);
        tick();
        chk("start_one_cycle", 32'(sif.stage_start), 0);
        repeat (dly - 1) tick();
        sif.stage_done = 6'(1 << k);
        tick();
        sif.stage_done = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        sif.enable     = 1'b0;
        sif.in_level   = '0;
        sif.out_level  = '0;
        sif.stage_done = '0;
        sif.clr_err    = 1'b0;
        repeat (2) tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk_zero("idle");

        // First frame: launch two cycles after enable, 3-cycle done latency.
        sif.enable   = 1'b1;
        sif.in_level = 12'd511;
        tick();
        chk("launch_not_early", 32'(sif.stage_start), 0);
        tick();
        chk("launch_start", 32'(sif.stage_start), 32'h01);
        chk("launch_stage_busy", 32'(sif.stage_busy), 32'h01);
        chk("launch_busy", 32'(sif.busy), 1);
        sif.in_level = 12'd510;
        for (int k = 0; k < 6; k++) begin
            step_stage(k, 3);
            if (k < 5) begin
                chk("next_start", 32'(sif.stage_start), 32'(1 << (k + 1)));
                chk("next_stage_busy", 32'(sif.stage_busy), 32'(1 << (k + 1)));
                chk("run_busy", 32'(sif.busy), 1);
            end
        end
        chk("frame_done_pulse", 32'(sif.frame_done), 1);
        chk("done_stage_busy", 32'(sif.stage_busy), 0);
        chk("done_busy_held", 32'(sif.busy), 1);
        chk("frame_cnt_1", 32'(sif.frame_cnt), 1);
        tick();
        chk("frame_done_cleared", 32'(sif.frame_done), 0);
        chk("busy_after_done", 32'(sif.busy), 0);

        // Launch gating on both FIFO levels.
        seen = 0;
        repeat (100) begin tick(); if (sif.stage_start != 0) seen = 1; end
        chk("no_launch_in510", 32'(seen), 0);
        sif.in_level  = 12'd600;
        sif.out_level = 12'd1537;
        seen = 0;
        repeat (100) begin tick(); if (sif.stage_start != 0) seen = 1; end
        chk("no_launch_out1537", 32'(seen), 0);
        sif.out_level = 12'd1536;
        tick();
        chk("launch_out1536", 32'(sif.stage_start), 32'h01);
        sif.in_level = '0;

        // Done filtering: wrong-index done and done during the start cycle.
        step_stage(0, 3);
        chk("stage1_start", 32'(sif.stage_start), 32'h02);
        sif.stage_done = 6'b001010;
        tick();
        chk("done_in_start_ignored", 32'(sif.stage_busy), 32'h02);
        sif.stage_done = 6'b001000;
        repeat (3) tick();
        chk("wrong_done_ignored", 32'(sif.stage_busy), 32'h02);
        chk("wrong_done_no_start", 32'(sif.stage_start), 0);
        sif.stage_done = '0;
        tick();
        sif.stage_done = 6'b000010;
        tick();
        sif.stage_done = '0;
        chk("stage2_start", 32'(sif.stage_start), 32'h04);

`ifdef HPSS_SEQ_WATCHDOG_EN
        seen = 0;
        repeat (49) begin tick(); if (sif.abort !== 1'b0) seen = 1; end
        chk("no_early_abort", 32'(seen), 0);
        tick();
        chk("abort_pulse", 32'(sif.abort), 1);
        chk("abort_tmo_err", 32'(sif.tmo_err), 1);
        chk("abort_err_stage", 32'(sif.err_stage), 2);
        chk("abort_busy", 32'(sif.busy), 0);
        chk("abort_stage_busy", 32'(sif.stage_busy), 0);
        chk("abort_frame_cnt", 32'(sif.frame_cnt), 1);
        tick();
        chk("abort_one_cycle", 32'(sif.abort), 0);
        chk("tmo_err_sticky", 32'(sif.tmo_err), 1);
        sif.clr_err = 1'b1;
        tick();
        sif.clr_err = 1'b0;
        chk("clr_tmo_err", 32'(sif.tmo_err), 0);
        chk("clr_err_stage", 32'(sif.err_stage), 0);
`else
        seen = 0;
        repeat (60) begin
            tick();
            if (sif.stage_busy !== 6'h04 || sif.busy !== 1'b1 || sif.abort !== 1'b0) seen = 1;
        end
        chk("no_watchdog_waits", 32'(seen), 0);
        sif.stage_done = 6'b000100;
        tick();
        sif.stage_done = '0;
        chk("stage3_start", 32'(sif.stage_start), 32'h08);
        for (int k = 3; k < 6; k++) step_stage(k, 2);
        chk("frame_cnt_2", 32'(sif.frame_cnt), 2);
        sif.clr_err = 1'b1;
        tick();
        sif.clr_err = 1'b0;
        chk("tmo_err_tied", 32'(sif.tmo_err), 0);
`endif

        // Counter wrap and enable drop mid-frame.
        sif.enable = 1'b0;
        repeat (2) tick();
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        tick();
        chk("preload", 32'(sif.frame_cnt), 32'hFFFF);
        sif.enable    = 1'b1;
        sif.in_level  = 12'd511;
        sif.out_level = 12'd0;
        repeat (2) tick();
        chk("wrap_launch", 32'(sif.stage_start), 32'h01);
        step_stage(0, 1);
        sif.enable = 1'b0;
        for (int k = 1; k < 6; k++) begin
            step_stage(k, 1);
            if (k < 5) chk("drop_en_continues", 32'(sif.stage_start), 32'(1 << (k + 1)));
        end
        chk("wrap_frame_done", 32'(sif.frame_done), 1);
        chk("wrap_frame_cnt", 32'(sif.frame_cnt), 0);
        seen = 0;
        repeat (10) begin tick(); if (sif.stage_start != 0 || sif.busy != 0) seen = 1; end
        chk("idle_after_drop", 32'(seen), 0);

        // Asynchronous reset at stage 4.
        sif.enable = 1'b1;
        repeat (2) tick();
        chk("rst_run_launch", 32'(sif.stage_start), 32'h01);
        sif.in_level = '0;
        for (int k = 0; k < 4; k++) step_stage(k, 1);
        chk("rst_stage4_start", 32'(sif.stage_start), 32'h10);
        tick();
        chk("rst_stage4_busy", 32'(sif.stage_busy), 32'h10);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        tick();
        rst = 1'b0;
        sif.enable = 1'b0;
        seen = 0;
        repeat (3) begin tick(); if (sif.stage_start != 0 || sif.busy != 0) seen = 1; end
        chk("no_start_after_rst", 32'(seen), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
